vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port master_clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-010 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-011 SHALL have port pixel_clk, input, 1 bit: divided pixel clock from clk_divider, sampled as data in the master_clk domain.
REQ-012 SHALL have port hcount, output, 10 bits: current pixel column.
REQ-013 SHALL have port vcount, output, 10 bits: current line.
REQ-014 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-015 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-016 SHALL have port active, output, 1 bit: high when hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-017 SHALL have port frame_start, output, 1 bit: one-master_clk pulse when the position wraps to (0,0).
REQ-018 SHALL have port frame_count, output, 8 bits: frame counter (see Configuration).

Function
REQ-019 SHALL register pixel_clk into pix_d every master_clk edge; tick = pixel_clk & ~pix_d.
REQ-020 SHALL advance counters only on master_clk edges where tick=1; otherwise all outputs hold.
REQ-021 SHALL, on tick, increment hcount; hcount wraps from H_TOTAL-1 to 0, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
REQ-022 SHALL increment vcount only on the tick where hcount wraps; vcount wraps from V_TOTAL-1 to 0, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-023 SHALL decode hsync, vsync, and active from the next-state counts and register them on the same edge, so they always match the hcount/vcount currently presented (zero skew).
REQ-024 SHALL drive hsync=0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-025 SHALL drive vsync=0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-026 SHALL pulse frame_start high for exactly one master_clk cycle, on the edge where the counters go from (799,524) to (0,0).
REQ-027 SHALL leave the counters unchanged if pixel_clk is held constant; a stuck pixel_clk freezes the raster without corruption.
REQ-028 SHALL size the internal count arithmetic so that no intermediate wraps for totals up to 1023.

Reset
REQ-029 SHALL, while rst=0, force hcount=0, vcount=0, hsync=1, vsync=1, active=1, frame_start=0, frame_count=0, and pix_d=1, independent of master_clk.
REQ-030 SHALL, with pix_d reset to 1, generate no tick from a pixel_clk that is already high at reset release; the first tick occurs on the first genuine rising edge.
REQ-031 SHALL abandon any partial line or frame on reset asserted mid-frame; the next frame starts at (0,0) with no frame_start pulse for the aborted frame.

Configuration
REQ-032 SHALL, when macro VGA_FRAME_CNT_EN is defined, increment frame_count (mod 256) on every frame_start pulse.
REQ-033 SHALL, when VGA_FRAME_CNT_EN is undefined, tie frame_count to 0 and synthesise no counter logic for it.

Verification
REQ-034 SHALL verify reset release: hold rst=0 for 100 ns with pixel_clk high, then release -> outputs equal the REQ-029 values, and there is no tick until the next pixel_clk rising edge.
REQ-035 SHALL verify line timing: run 800 ticks -> hsync low for exactly ticks 656..751, hcount returns to 0, and vcount=1.
REQ-036 SHALL verify frame timing: run 420000 ticks -> vsync low only on lines 490..491, and exactly one frame_start at the wrap to (0,0).
REQ-037 SHALL verify the active window: active=1 for hcount 0..639 on vcount 0..479, active=0 at hcount=640 and at vcount=480.
REQ-038 SHALL verify mid-frame reset: assert rst at (300,200) -> immediate (0,0) with no frame_start; after release, the first frame_start occurs a full 420000 ticks later.
REQ-039 SHALL verify VGA_FRAME_CNT_EN: with the macro defined, 3 frames give frame_count=3; with it undefined, frame_count stays 0.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: counts pixels/lines on rising edges of a sampled pixel clock
// and produces zero-skew registered syncs. Optional frame counter enabled by VGA_FRAME_CNT_EN.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       master_clk,
    input  logic       rst,
    input  logic       pixel_clk,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    // One spare bit so sums like H_ACTIVE+H_FP+H_SYNC compare without wrapping.
    localparam int CW = 11;
    localparam logic [CW-1:0] H_TOTAL  = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [CW-1:0] V_TOTAL  = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic          r_pix_d;
    logic [9:0]    r_hcount;
    logic [9:0]    r_vcount;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_active;
    logic          r_frame_start;

    logic          w_tick;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [9:0]    w_h_next;
    logic [9:0]    w_v_next;
    logic [CW-1:0] w_h_next_ext;
    logic [CW-1:0] w_v_next_ext;

    assign w_tick = pixel_clk & ~r_pix_d;

    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        w_h_wrap     = ({1'b0, r_hcount} == H_TOTAL - CW'(1));
        w_v_wrap     = ({1'b0, r_vcount} == V_TOTAL - CW'(1));
        w_h_next     = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
        w_v_next     = r_vcount;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? 10'd0 : r_vcount + 10'd1;
        end
        w_h_next_ext = {1'b0, w_h_next};
        w_v_next_ext = {1'b0, w_v_next};
    end

    // Syncs are decoded from the next counts so they land on the same edge as the counts.
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            r_pix_d       <= 1'b1;
            r_hcount      <= 10'd0;
            r_vcount      <= 10'd0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_active      <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_d       <= pixel_clk;
            r_frame_start <= 1'b0;
            if (w_tick) begin
                r_hcount      <= w_h_next;
                r_vcount      <= w_v_next;
                r_hsync       <= !((w_h_next_ext >= HS_START) && (w_h_next_ext < HS_END));
                r_vsync       <= !((w_v_next_ext >= VS_START) && (w_v_next_ext < VS_END));
                r_active      <= (w_h_next_ext < H_ACT) && (w_v_next_ext < V_ACT);
                r_frame_start <= w_h_wrap & w_v_wrap;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] r_frame_count;

    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            r_frame_count <= 8'd0;
        end else if (w_tick && w_h_wrap && w_v_wrap) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = 8'd0;
`endif

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default-timing instance for line checks, a shrunken
// instance (16x11 raster) for whole-frame, vsync and reset-abort checks.
module tb_vga_sync_gen;

    // Shrunken raster: hsync low on h 10..12, vsync low on v 7..8, active h<8 && v<6.
    localparam int SH_TOTAL = 16;
    localparam int SV_TOTAL = 11;
    localparam int S_FRAME  = SH_TOTAL * SV_TOTAL;

    logic       master_clk = 1'b0;
    logic       rst        = 1'b0;
    logic       pixel_clk  = 1'b0;

    logic [9:0] d_hcount, d_vcount, s_hcount, s_vcount;
    logic       d_hsync, d_vsync, d_active, d_frame_start;
    logic       s_hsync, s_vsync, s_active, s_frame_start;
    logic [7:0] d_frame_count, s_frame_count;

    int checks   = 0;
    int failures = 0;

    always #5 master_clk = ~master_clk;

    vga_sync_gen u_dut (
        .master_clk  (master_clk),
        .rst         (rst),
        .pixel_clk   (pixel_clk),
        .hcount      (d_hcount),
        .vcount      (d_vcount),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .active      (d_active),
        .frame_start (d_frame_start),
        .frame_count (d_frame_count)
    );

    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2)
    ) u_small (
        .master_clk  (master_clk),
        .rst         (rst),
        .pixel_clk   (pixel_clk),
        .hcount      (s_hcount),
        .vcount      (s_vcount),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .active      (s_active),
        .frame_start (s_frame_start),
        .frame_count (s_frame_count)
    );

    // One pixel_clk rising edge, seen by exactly one master_clk edge; returns at a negedge.
    task automatic do_tick;
        @(negedge master_clk);
        pixel_clk = 1'b1;
        @(negedge master_clk);
        pixel_clk = 1'b0;
    endtask

    task automatic apply_reset;
        @(negedge master_clk);
        rst       = 1'b0;
        pixel_clk = 1'b0;
        repeat (3) @(negedge master_clk);
        rst = 1'b1;
        repeat (2) @(negedge master_clk);
    endtask

    task automatic test_reset;
        @(negedge master_clk);
        rst       = 1'b0;
        pixel_clk = 1'b1;
        #100;
        checks++;
        if ({d_hcount, d_vcount, d_hsync, d_vsync, d_active, d_frame_start, d_frame_count} !==
            {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_default: got h=%0d v=%0d hs=%b vs=%b act=%b fs=%b fc=%0d, want 0 0 1 1 1 0 0",
                     d_hcount, d_vcount, d_hsync, d_vsync, d_active, d_frame_start, d_frame_count);
        end
        checks++;
        if ({s_hcount, s_vcount, s_hsync, s_vsync, s_active, s_frame_start, s_frame_count} !==
            {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL reset_small: got h=%0d v=%0d hs=%b vs=%b act=%b fs=%b fc=%0d, want 0 0 1 1 1 0 0",
                     s_hcount, s_vcount, s_hsync, s_vsync, s_active, s_frame_start, s_frame_count);
        end
        @(negedge master_clk);
        rst = 1'b1;
        repeat (5) @(negedge master_clk);
        checks++;
        if (d_hcount !== 10'd0) begin
            failures++;
            $display("FAIL no_tick_high_at_release: hcount=%0d want 0", d_hcount);
        end
        pixel_clk = 1'b0;
        repeat (2) @(negedge master_clk);
        checks++;
        if (d_hcount !== 10'd0) begin
            failures++;
            $display("FAIL no_tick_on_fall: hcount=%0d want 0", d_hcount);
        end
        pixel_clk = 1'b1;
        @(negedge master_clk);
        checks++;
        if (d_hcount !== 10'd1 || s_hcount !== 10'd1) begin
            failures++;
            $display("FAIL first_genuine_tick: hcount=%0d/%0d want 1", d_hcount, s_hcount);
        end
        pixel_clk = 1'b0;
    endtask

    task automatic test_line;
        int  eh;
        int  ev;
        logic e_hs;
        logic e_act;
        apply_reset();
        for (int t = 1; t <= 800; t++) begin
            do_tick();
            eh    = t % 800;
            ev    = (t == 800) ? 1 : 0;
            e_hs  = !(eh >= 656 && eh < 752);
            e_act = (eh < 640) && (ev < 480);
            checks++;
            if (d_hcount !== 10'(eh) || d_vcount !== 10'(ev)) begin
                failures++;
                $display("FAIL line_count t=%0d: got (%0d,%0d) want (%0d,%0d)", t, d_hcount, d_vcount, eh, ev);
            end
            checks++;
            if (d_hsync !== e_hs || d_vsync !== 1'b1) begin
                failures++;
                $display("FAIL line_sync t=%0d: hs=%b vs=%b want hs=%b vs=1", t, d_hsync, d_vsync, e_hs);
            end
            checks++;
            if (d_active !== e_act || d_frame_start !== 1'b0) begin
                failures++;
                $display("FAIL line_active t=%0d: act=%b fs=%b want act=%b fs=0", t, d_active, d_frame_start, e_act);
            end
        end
    endtask

    task automatic test_hold;
        // A stuck pixel_clk, low or high, must freeze the raster after at most one tick.
        repeat (20) @(negedge master_clk);
        checks++;
        if (d_hcount !== 10'd0 || d_vcount !== 10'd1) begin
            failures++;
            $display("FAIL hold_low: got (%0d,%0d) want (0,1)", d_hcount, d_vcount);
        end
        pixel_clk = 1'b1;
        repeat (20) @(negedge master_clk);
        checks++;
        if (d_hcount !== 10'd1 || d_vcount !== 10'd1) begin
            failures++;
            $display("FAIL hold_high: got (%0d,%0d) want (1,1)", d_hcount, d_vcount);
        end
        pixel_clk = 1'b0;
    endtask

    task automatic test_frame;
        int   h = 0;
        int   v = 0;
        int   fs_seen = 0;
        logic e_fs;
        logic [7:0] e_fc;
        apply_reset();
        for (int t = 1; t <= 3 * S_FRAME; t++) begin
            do_tick();
            h = h + 1;
            if (h == SH_TOTAL) begin
                h = 0;
                v = (v == SV_TOTAL - 1) ? 0 : v + 1;
            end
            e_fs = (h == 0) && (v == 0);
            if (s_frame_start === 1'b1) fs_seen++;
            checks++;
            if (s_hcount !== 10'(h) || s_vcount !== 10'(v)) begin
                failures++;
                $display("FAIL frame_count_pos t=%0d: got (%0d,%0d) want (%0d,%0d)", t, s_hcount, s_vcount, h, v);
            end
            checks++;
            if (s_hsync !== !(h >= 10 && h < 13) || s_vsync !== !(v >= 7 && v < 9)) begin
                failures++;
                $display("FAIL frame_sync t=%0d at (%0d,%0d): hs=%b vs=%b", t, h, v, s_hsync, s_vsync);
            end
            checks++;
            if (s_active !== ((h < 8) && (v < 6)) || s_frame_start !== e_fs) begin
                failures++;
                $display("FAIL frame_active t=%0d at (%0d,%0d): act=%b fs=%b want fs=%b", t, h, v, s_active, s_frame_start, e_fs);
            end
        end
        checks++;
        if (fs_seen != 3) begin
            failures++;
            $display("FAIL frame_start_total: got %0d pulses want 3", fs_seen);
        end
`ifdef VGA_FRAME_CNT_EN
        e_fc = 8'd3;
`else
        e_fc = 8'd0;
`endif
        checks++;
        if (s_frame_count !== e_fc || d_frame_count !== 8'd0) begin
            failures++;
            $display("FAIL frame_counter: small=%0d want %0d, default=%0d want 0", s_frame_count, e_fc, d_frame_count);
        end
    endtask

    task automatic test_mid_reset;
        int fs_seen = 0;
        logic [7:0] e_fc;
        apply_reset();
        repeat (3 * SH_TOTAL + 5) do_tick();
        checks++;
        if (s_hcount !== 10'd5 || s_vcount !== 10'd3) begin
            failures++;
            $display("FAIL mid_reset_setup: got (%0d,%0d) want (5,3)", s_hcount, s_vcount);
        end
        @(negedge master_clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (s_hcount !== 10'd0 || s_vcount !== 10'd0 || s_frame_start !== 1'b0 || d_hcount !== 10'd0) begin
            failures++;
            $display("FAIL mid_reset_async: small (%0d,%0d) fs=%b default h=%0d want (0,0) fs=0 h=0",
                     s_hcount, s_vcount, s_frame_start, d_hcount);
        end
        @(negedge master_clk);
        rst = 1'b1;
        repeat (2) @(negedge master_clk);
        for (int t = 1; t <= S_FRAME; t++) begin
            do_tick();
            if (s_frame_start === 1'b1) fs_seen++;
            checks++;
            if (s_frame_start !== (t == S_FRAME)) begin
                failures++;
                $display("FAIL mid_reset_fs t=%0d: fs=%b want %b", t, s_frame_start, (t == S_FRAME));
            end
        end
`ifdef VGA_FRAME_CNT_EN
        e_fc = 8'd1;
`else
        e_fc = 8'd0;
`endif
        checks++;
        if (fs_seen != 1 || s_hcount !== 10'd0 || s_vcount !== 10'd0 || s_frame_count !== e_fc) begin
            failures++;
            $display("FAIL mid_reset_frame: pulses=%0d pos=(%0d,%0d) fc=%0d want 1 (0,0) %0d",
                     fs_seen, s_hcount, s_vcount, s_frame_count, e_fc);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_hold();
        test_frame();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
